// File: rtl/rx_stream_arbiter.sv
// Rotating-priority arbiter that merges WIDTH FWFT RX FIFOs onto one downstream write port.
// Optional per-source written-word counters on GRANT_WORDS when ARB_STAT_EN is defined.
module rx_stream_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned BURST = 16
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_N,
  input  logic                EN,
  input  logic [WIDTH-1:0]    REQ_EMPTY,
  input  logic [WIDTH-1:0]    REQ_HOLD,
  input  logic [WIDTH*DW-1:0] REQ_DATA,
  output logic [WIDTH-1:0]    REQ_READ,
  input  logic                OUT_FULL,
  output logic                OUT_WRITE,
  output logic [DW-1:0]       OUT_DATA,
  output logic [WIDTH-1:0]    GRANT,
  output logic                BUSY
`ifdef ARB_STAT_EN
  ,
  output logic [WIDTH*16-1:0] GRANT_WORDS
`endif
);

  localparam int unsigned OW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW   = (BURST > 0) ? $clog2(BURST + 1) : 1;
  localparam int unsigned CMAX = (BURST > 0) ? BURST - 1 : 0;

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   owner, owner_nx, last_owner, last_owner_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0] grant_nx;
  logic            busy_nx, out_write_nx;
  logic [DW-1:0]   out_data_nx;
  logic            rd, hold;
  logic [OW-1:0]   pick;
  logic            pick_vld;
  int unsigned     idx;
  logic [DW-1:0]   data_arr [WIDTH];

  for (genvar g = 0; g < WIDTH; g++) begin : g_unpack
    assign data_arr[g] = REQ_DATA[g*DW +: DW];
  end

  // First non-empty source after last_owner, wrapping modulo WIDTH
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      idx = (32'(last_owner) + k) % WIDTH;
      if (!pick_vld && !REQ_EMPTY[OW'(idx)]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    cnt_nx        = cnt;
    grant_nx      = GRANT;
    busy_nx       = BUSY;
    out_write_nx  = 1'b0;
    out_data_nx   = OUT_DATA;
    REQ_READ      = '0;
    rd            = 1'b0;
    hold          = 1'b0;
    case (state)
      IDLE: begin
        if (EN && pick_vld) begin
          state_nx = XFER;
          owner_nx = pick;
          grant_nx = WIDTH'(1) << pick;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
        end
      end
      XFER: begin
        rd              = EN & ~REQ_EMPTY[owner] & ~OUT_FULL;
        hold            = REQ_HOLD[owner];
        REQ_READ[owner] = rd;
        if (rd) begin
          out_write_nx = 1'b1;
          out_data_nx  = data_arr[owner];
          if (cnt != CW'(CMAX)) cnt_nx = cnt + 1'b1;
        end
        // Burst-limit exit still lets this cycle's read through
        if (!EN || (!hold && REQ_EMPTY[owner]) ||
            (!hold && (BURST != 0) && rd && (cnt == CW'(CMAX)))) begin
          state_nx      = IDLE;
          grant_nx      = '0;
          busy_nx       = 1'b0;
          last_owner_nx = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(WIDTH - 1);
      cnt        <= '0;
      GRANT      <= '0;
      BUSY       <= 1'b0;
      OUT_WRITE  <= 1'b0;
      OUT_DATA   <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      cnt        <= cnt_nx;
      GRANT      <= grant_nx;
      BUSY       <= busy_nx;
      OUT_WRITE  <= out_write_nx;
      OUT_DATA   <= out_data_nx;
    end
  end

`ifdef ARB_STAT_EN
  logic [OW-1:0] wr_src;
  logic [15:0]   words [WIDTH];

  // wr_src follows the read so the count lands on the cycle OUT_WRITE is high
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_src <= '0;
      for (int i = 0; i < WIDTH; i++) words[i] <= '0;
    end else begin
      if (rd) wr_src <= owner;
      if (OUT_WRITE && (words[wr_src] != 16'hFFFF)) words[wr_src] <= words[wr_src] + 16'd1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_stat
    assign GRANT_WORDS[g*16 +: 16] = words[g];
  end
`endif

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter: queue-level source FIFOs and a round-robin burst planner.
module tb_rx_stream_arbiter;
  localparam int unsigned W  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned B  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            out_full = 1'b0;
  logic [W-1:0]    req_empty, req_hold, req_read, grant;
  logic [W*DW-1:0] req_data;
  logic            out_write, busy;
  logic [DW-1:0]   out_data;
`ifdef ARB_STAT_EN
  logic [W*16-1:0] grant_words;
`endif

  always #5 clk = ~clk;

  rx_stream_arbiter #(.WIDTH(W), .DW(DW), .BURST(B)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .EN(en),
    .REQ_EMPTY(req_empty), .REQ_HOLD(req_hold), .REQ_DATA(req_data),
    .REQ_READ(req_read), .OUT_FULL(out_full), .OUT_WRITE(out_write),
    .OUT_DATA(out_data), .GRANT(grant), .BUSY(busy)
`ifdef ARB_STAT_EN
    , .GRANT_WORDS(grant_words)
`endif
  );

  logic [DW-1:0] srcq [W][$];
  logic [DW-1:0] exp_q [$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [W-1:0]  rd_seen = '0;
  int            run_len = 0, gap_len = 0;
  int            runs [$];
  int            gaps [$];
  int            model_last = W - 1;
  bit            rand_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    req_empty = '0;
    req_data  = '0;
    for (int i = 0; i < W; i++) begin
      if (srcq[i].size() == 0) begin
        req_empty = req_empty | (W'(1) << i);
        req_data  = req_data | ((W*DW)'(32'hDEAD_0000 | 32'(i)) << (i*DW));
      end else begin
        req_data  = req_data | ((W*DW)'(srcq[i][0]) << (i*DW));
      end
    end
  endtask

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) srcq[s].push_back($urandom());
  endtask

  task automatic expect_src(input int s);
    for (int k = 0; k < srcq[s].size(); k++) exp_q.push_back(srcq[s][k]);
  endtask

  // Whole-queue round robin: each turn takes up to B words from the next non-empty source
  function automatic void plan();
    int  left [W];
    int  pos [W];
    int  o, n;
    bit  found;
    for (int i = 0; i < W; i++) begin left[i] = srcq[i].size(); pos[i] = 0; end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      o = 0;
      for (int k = 1; k <= W; k++) begin
        if (!found && left[(model_last + k) % W] > 0) begin
          o = (model_last + k) % W;
          found = 1'b1;
        end
      end
      if (found) begin
        n = (left[o] < B) ? left[o] : B;
        for (int k = 0; k < n; k++) exp_q.push_back(srcq[o][pos[o] + k]);
        pos[o] += n;
        left[o] -= n;
        model_last = o;
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    chk("read_onehot0", 32'($onehot0(req_read)), 32'd1);
    chk("read_only_nonempty", 32'(req_read & req_empty), 32'd0);
    chk("read_within_grant", 32'(req_read & ~grant), 32'd0);
    if (out_full || !en) chk("read_blocked", 32'(req_read), 32'd0);
    chk("busy_eq_grant", 32'(busy), 32'(grant != '0));
    if (out_write) begin
      if (exp_q.size() == 0) chk("write_expected", 32'(exp_q.size()), 32'd1);
      else chk("out_data", out_data, exp_q.pop_front());
      if (gap_len > 0 && runs.size() > 0) gaps.push_back(gap_len);
      gap_len = 0;
      run_len++;
    end else begin
      if (run_len > 0) runs.push_back(run_len);
      run_len = 0;
      gap_len++;
    end
    rd_seen = req_read;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++)
      if (rd_seen[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    rd_seen = '0;
    if (rand_full) out_full = ($urandom_range(0, 3) == 0);
    drive();
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic drain(input int bound, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || busy) && n < bound) begin
      cycle();
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < bound), 32'd1);
    chk({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < W; i++) srcq[i].delete();
    exp_q.delete();
    rd_seen = '0;
    advance();
    rst_n = 1'b1;
    model_last = W - 1;
  endtask

  initial begin
    req_hold = '0;
    en = 1'b1;
    drive();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_write", 32'(out_write), 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // Single source 2 with five words
    load(2, 5);
    expect_src(2);
    drive();
    advance();
    rst_n = 1'b1;
    sample(); chk("t1_idle_first", 32'(grant), 32'd0); advance();
    sample(); chk("t1_grant", 32'(grant), 32'b0100); chk("t1_busy", 32'(busy), 32'd1); advance();
    for (int k = 0; k < 5; k++) begin
      sample(); chk("t1_write_run", 32'(out_write), 32'd1); advance();
    end
    sample(); chk("t1_write_done", 32'(out_write), 32'd0); chk("t1_grant_idle", 32'(grant), 32'd0); advance();

    // After owner 2, source 3 beats source 0
    load(0, 1); load(3, 1);
    exp_q.push_back(srcq[3][0]);
    exp_q.push_back(srcq[0][0]);
    drive();
    sample(); advance();
    sample(); chk("last_owner_rotation", 32'(grant), 32'b1000); advance();
    drain(50, "t1b");

    // Fairness: all sources with 40 words
    do_reset();
    for (int s = 0; s < W; s++) load(s, 40);
    plan();
    drive();
    runs.delete(); gaps.delete(); run_len = 0; gap_len = 0;
    drain(1000, "fair");
    chk("fair_run_count_ok", 32'(runs.size() >= 8 && gaps.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < runs.size()) chk("fair_burst_len", 32'(runs[k]), 32'd16);
      if (k < gaps.size()) chk("fair_gap_len", 32'(gaps[k]), 32'd1);
    end

    // Backpressure mid-burst on source 1
    load(1, 10);
    plan();
    drive();
    sample(); advance();
    sample(); chk("t3_grant", 32'(grant), 32'b0010); advance();
    repeat (3) cycle();
    out_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("t3_full_no_read", 32'(req_read), 32'd0);
      chk("t3_full_grant", 32'(grant), 32'b0010);
      if (k > 0) chk("t3_full_no_write", 32'(out_write), 32'd0);
      advance();
    end
    out_full = 1'b0;
    drain(100, "t3");

    // Hold on source 0 past burst and while empty
    do_reset();
    req_hold = 4'b0001;
    load(0, 20); load(3, 3);
    expect_src(0); expect_src(3);
    drive();
    runs.delete(); gaps.delete(); run_len = 0; gap_len = 0;
    for (int n = 0; n < 40 && srcq[0].size() > 0; n++) cycle();
    chk("t4_src0_drained", 32'(srcq[0].size()), 32'd0);
    for (int k = 0; k < 10; k++) begin
      sample(); chk("t4_hold_grant", 32'(grant), 32'b0001); advance();
    end
    chk("t4_run_seen", 32'(runs.size() > 0), 32'd1);
    if (runs.size() > 0) chk("t4_hold_run_len", 32'(runs[0]), 32'd20);
    req_hold = '0;
    sample(); chk("t4_exit_cycle", 32'(grant), 32'b0001); advance();
    sample(); chk("t4_idle", 32'(grant), 32'd0); advance();
    sample(); chk("t4_src3_grant", 32'(grant), 32'b1000); advance();
    drain(50, "t4");
    model_last = 3;

    // EN dropped mid-burst on source 2
    load(2, 10);
    plan();
    drive();
    sample(); advance();
    sample(); chk("t5_grant", 32'(grant), 32'b0100); advance();
    repeat (3) cycle();
    en = 1'b0;
    sample(); chk("t5_no_read", 32'(req_read), 32'd0); chk("t5_last_write", 32'(out_write), 32'd1); advance();
    sample(); chk("t5_idle", 32'(grant), 32'd0); chk("t5_no_write", 32'(out_write), 32'd0); advance();
    for (int k = 0; k < 4; k++) begin
      sample(); chk("t5_no_grant_while_off", 32'(grant), 32'd0); advance();
    end
    en = 1'b1;
    drain(100, "t5");

    // Random loads with random backpressure, async reset mid-transfer
    do_reset();
    for (int s = 0; s < W; s++) load(s, $urandom_range(8, 40));
    plan();
    drive();
    rand_full = 1'b1;
    repeat (25) cycle();
    for (int n = 0; n < 50 && !busy; n++) cycle();
    chk("t6_busy_before_reset", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out_write", 32'(out_write), 32'd0);
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    do_reset();
    for (int s = 0; s < W; s++) load(s, $urandom_range(1, 40));
    plan();
    drive();
    sample(); advance();
    sample(); chk("t6_src0_first", 32'(grant), 32'b0001); advance();
    drain(3000, "t6");
    rand_full = 1'b0;
    out_full = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_stream_arbiter.md
Name: rx_stream_arbiter

Overview:
- Time-shares the single 32-bit write port of the output BRAM FIFO between WIDTH first-word-fall-through RX FIFOs, one per FE-I4 receiver.
- Uses rotating priority with a per-grant burst limit and a per-source hold.
- Honours downstream backpressure.
- Sits between the fei4_rx instances and bram_fifo on BUS_CLK, replacing the simple round-robin arbiter.

Parameters:
- WIDTH, 4: number of requesting sources (2..16).
- DW, 32: data word width.
- BURST, 16: maximum words transferred per grant before priority rotates; 0 = unlimited.

Ports:
- BUS_CLK  in  1  system clock; all logic on its rising edge.
- BUS_RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  global enable; 0 stops new reads and new grants.
- REQ_EMPTY  in  WIDTH  source FIFO empty flags (FWFT).
- REQ_HOLD  in  WIDTH  source requests to keep the grant while empty and past burst.
- REQ_DATA  in  WIDTH*DW  source FWFT data, source i at [i*DW +: DW].
- REQ_READ  out  WIDTH  pop strobe to the owning source; combinational; at most one bit high.
- OUT_FULL  in  1  downstream cannot accept another read this cycle; must leave ≥1 word of headroom.
- OUT_WRITE  out  1  registered write strobe to the downstream FIFO.
- OUT_DATA  out  DW  registered write data.
- GRANT  out  WIDTH  registered one-hot current owner; 0 when idle.
- BUSY  out  1  registered; 1 while in state XFER.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, GRANT=0, BUSY=0, OUT_WRITE=0, OUT_DATA=0.
  - burst counter=0, last_owner=WIDTH-1, so source 0 wins first.
- State IDLE:
  - If EN and any REQ_EMPTY[i]=0: select the first non-empty source scanning last_owner+1, last_owner+2, … modulo WIDTH.
  - On selection: register owner, GRANT=onehot(owner), counter=0, go to XFER.
  - No read is issued in IDLE, so arbitration costs exactly 1 cycle.
  - Otherwise stay in IDLE.
- State XFER:
  - rd = EN & !REQ_EMPTY[owner] & !OUT_FULL.
  - REQ_READ[owner]=rd in the same cycle.
  - On rd: OUT_DATA<=REQ_DATA[owner], OUT_WRITE<=1 on the next edge, counter+1. Otherwise OUT_WRITE<=0.
  - Read-to-write latency is 1 cycle; throughput is 1 word/cycle while the owner has data.
- Leave XFER for IDLE (GRANT<=0, BUSY<=0, last_owner<=owner) on the first cycle any of these holds:
  - (a) EN=0.
  - (b) REQ_HOLD[owner]=0 and REQ_EMPTY[owner]=1.
  - (c) REQ_HOLD[owner]=0, BURST≠0, rd=1 and counter=BURST-1. The final read still happens in this cycle.
- Hold:
  - While REQ_HOLD[owner]=1, the grant is kept regardless of empty or burst count.
  - The counter saturates at BURST-1 and does not wrap.
  - Dropping hold re-evaluates (b) and (c) in the same cycle.
- OUT_FULL=1 in XFER:
  - No read and no exit for that reason; the grant is kept.
  - Exit can still occur via (a) or (b).
- Simultaneous events:
  - The hold of a non-owner has no effect.
  - A requester becoming non-empty mid-burst waits for rotation.
  - A requester becoming non-empty on the exit cycle is considered in the next IDLE cycle.
- Fairness: with all sources continuously non-empty, grants cycle 0,1,2,…,WIDTH-1,0 with BURST words each plus 1 idle cycle between grants.
- Reset mid-operation: all outputs return to reset values immediately (async). The in-flight word is dropped by design.
- Counter width: $clog2(BURST+1), minimum 1.
- Sources with REQ_EMPTY=1 are never read.

Optional Feature:
- Macro: ARB_STAT_EN.
- Defined:
  - Adds output GRANT_WORDS, WIDTH*16 bits: per-source counts of words written.
  - Each count is 16 bits, saturates at 16'hFFFF, and is cleared by reset.
  - A count increments on the cycle OUT_WRITE=1 for that source.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then only source 2 non-empty with 5 words, BURST=16 → GRANT=4'b0100 one cycle after reset release; 5 consecutive OUT_WRITE pulses with the words in order; then IDLE, GRANT=0, last_owner=2.
- All 4 sources full with 40 words, BURST=16 → grant order 0,1,2,3,0…; exactly 16 writes per grant; 1 gap cycle between grants.
- Source 1 owner, OUT_FULL high for 3 cycles mid-burst → REQ_READ=0 and OUT_WRITE=0 for those cycles; GRANT stays 4'b0010; burst resumes with no word lost or duplicated.
- Source 0 with REQ_HOLD=1 and empty for 10 cycles while source 3 is non-empty → GRANT stays 4'b0001. Hold drops with source 0 still empty → IDLE next cycle, then source 3 granted.
- EN deasserted mid-burst → no further REQ_READ that cycle; the last issued word is still written one cycle later; IDLE. No grant until EN=1.
- BUS_RST_N pulsed low mid-transfer → OUT_WRITE, GRANT and BUSY go to 0 without a clock edge. After release, source 0 has priority.
